// File: rtl/fsm_cmd_sched.sv
// Command scheduler for the small mode FSM.
// Requesters are arbitrated round-robin. Each legal command is held on
// fsm_cmd for HOLD_CYCLES cycles, and then the FSM's reported state is
// checked. Illegal commands, state-check mismatches and unused state
// encodings set err_sticky. A mismatch or an unused encoding also runs a
// recovery sequence that drives the FSM back to state 0.

package fsm_cmd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_ARB     = 3'b001,
    ST_DRIVE   = 3'b010,
    ST_CHECK   = 3'b011,
    ST_RECOVER = 3'b100
  } state_e;

endpackage

module fsm_cmd_sched
  import fsm_cmd_sched_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int GW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_cmd,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_err,
  output logic [GW-1:0]        grant_id,
  output logic [2:0]           fsm_cmd,
  input  logic [2:0]           fsm_state,
  output logic                 busy,
  output logic                 err_sticky
);

  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);
  localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0]      CMD_MAX   = 3'd2;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              resp_err_q, resp_err_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [2:0]        fsm_cmd_q, fsm_cmd_d;
  logic              busy_q, busy_d;
  logic              err_sticky_q, err_sticky_d;
  logic [GW-1:0]     last_q, last_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [3:0]        cnt_q, cnt_d;
  // Set when RECOVER follows a failed check and so owes the requester a pulse.
  logic              rec_pulse_q, rec_pulse_d;

  logic [NREQ-1:0]   elig;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [2:0]        pick_cmd;
  logic              hold_done;
  logic              check_ok;

  assign hold_done = (cnt_q == HOLD_LAST);
  assign check_ok  = (fsm_state == cmd_q);

  // Round-robin pick: the lowest eligible index above last_q, else wrap to the lowest eligible.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    elig       = req_valid & ~req_ready_q;
    pick_found = |elig;
    pick_idx   = '0;
    pick_cmd   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_idx = GW'(i);
        pick_cmd = req_cmd[3*i +: 3];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i] && (i > int'(last_q))) begin
        pick_idx = GW'(i);
        pick_cmd = req_cmd[3*i +: 3];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of block order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; any unused encoding falls into RECOVER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|elig) state_d = ST_ARB;
      ST_ARB: begin
        if (pick_found && (pick_cmd <= CMD_MAX)) state_d = ST_DRIVE;
        else                                     state_d = ST_IDLE;
      end
      ST_DRIVE:   if (hold_done) state_d = ST_CHECK;
      ST_CHECK:   state_d = check_ok ? ST_IDLE : ST_RECOVER;
      ST_RECOVER: if (hold_done) state_d = ST_IDLE;
      default:    state_d = ST_RECOVER;
    endcase
  end

  // Output and datapath next values; the values are registered below so that every output is a flop.
  always_comb begin
    req_ready_d  = '0;
    resp_err_d   = 1'b0;
    grant_id_d   = grant_id_q;
    fsm_cmd_d    = 3'd0;
    busy_d       = (state_d != ST_IDLE);
    err_sticky_d = err_sticky_q;
    last_d       = last_q;
    cmd_d        = cmd_q;
    cnt_d        = '0;
    rec_pulse_d  = rec_pulse_q;
    case (state_q)
      ST_IDLE: ;
      ST_ARB: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          last_d     = pick_idx;
          cmd_d      = pick_cmd;
          if (pick_cmd <= CMD_MAX) begin
            fsm_cmd_d = pick_cmd;
          end else begin
            req_ready_d  = ONE_HOT0 << pick_idx;
            resp_err_d   = 1'b1;
            err_sticky_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        // Also covers the CHECK cycle, which must keep the command on fsm_cmd.
        fsm_cmd_d = cmd_q;
        if (!hold_done) cnt_d = cnt_q + 4'd1;
      end
      ST_CHECK: begin
        if (check_ok) begin
          req_ready_d = ONE_HOT0 << grant_id_q;
        end else begin
          err_sticky_d = 1'b1;
          rec_pulse_d  = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (!hold_done) begin
          cnt_d = cnt_q + 4'd1;
        end else if (rec_pulse_q) begin
          req_ready_d = ONE_HOT0 << grant_id_q;
          resp_err_d  = 1'b1;
          rec_pulse_d = 1'b0;
        end
      end
      default: begin
        err_sticky_d = 1'b1;
        rec_pulse_d  = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q  <= '0;
      resp_err_q   <= 1'b0;
      grant_id_q   <= '0;
      fsm_cmd_q    <= 3'd0;
      busy_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      last_q       <= GW'(NREQ - 1);
      cmd_q        <= 3'd0;
      cnt_q        <= '0;
      rec_pulse_q  <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_err_q   <= resp_err_d;
      grant_id_q   <= grant_id_d;
      fsm_cmd_q    <= fsm_cmd_d;
      busy_q       <= busy_d;
      err_sticky_q <= err_sticky_d;
      last_q       <= last_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      rec_pulse_q  <= rec_pulse_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_err   = resp_err_q;
  assign grant_id   = grant_id_q;
  assign fsm_cmd    = fsm_cmd_q;
  assign busy       = busy_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fsm_cmd_sched.sv
// Directed bench for fsm_cmd_sched (NREQ=4, HOLD_CYCLES=2) with a small
// model of the mode FSM that follows fsm_cmd one cycle late, or sticks at 0.

module tb_fsm_cmd_sched;

  localparam int NREQ = 4;
  localparam int H    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_cmd = '0;
  logic [3:0]  req_ready;
  logic        resp_err;
  logic [1:0]  grant_id;
  logic [2:0]  fsm_cmd;
  logic [2:0]  fsm_state = 3'd0;
  logic        busy;
  logic        err_sticky;
  logic        stuck = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fsm_cmd_sched #(.NREQ(NREQ), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_ready  (req_ready),
    .resp_err   (resp_err),
    .grant_id   (grant_id),
    .fsm_cmd    (fsm_cmd),
    .fsm_state  (fsm_state),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Mode FSM model: adopts the command one cycle after it appears.
  always @(posedge clk) fsm_state <= stuck ? 3'd0 : fsm_cmd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input int idx, input logic [2:0] c);
    req_cmd[3*idx +: 3] = c;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    stuck     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Steps until a req_ready pulse or the bound; idx is -1 on timeout.
  task automatic wait_ready(input int bound, output int idx, output int cycles);
    idx    = -1;
    cycles = 0;
    while (cycles < bound) begin
      step();
      cycles++;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        break;
      end
    end
  endtask

  logic [2:0] exp_cmd_legal [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
  logic [3:0] exp_rdy_legal [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
  logic [2:0] exp_cmd_mm    [7] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0};
  logic [3:0] exp_rdy_mm    [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
  int         exp_rr_order  [5] = '{0, 1, 2, 3, 0};

  initial begin
    int idx;
    int cyc;

    // Reset values
    do_reset();
    step();
    check("rst_fsm_cmd", 32'(fsm_cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

    // Single legal command: requester 2, cmd 1
    set_cmd(2, 3'd1);
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("legal_fsm_cmd_c%0d", k + 1), 32'(fsm_cmd), 32'(exp_cmd_legal[k]));
      check($sformatf("legal_ready_c%0d", k + 1), 32'(req_ready), 32'(exp_rdy_legal[k]));
    end
    check("legal_resp_err", 32'(resp_err), 32'd0);
    check("legal_grant_id", 32'(grant_id), 32'd2);
    check("legal_busy_done", 32'(busy), 32'd0);
    req_valid = 4'b0000;
    step();
    check("legal_ready_one_cycle", 32'(req_ready), 32'd0);

    // Round-robin: all four request cmd 2; requester 0 re-requests after 1 completes
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 3'd2);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ready(12, idx, cyc);
      check($sformatf("rr_grant_%0d", n), 32'(idx), 32'(exp_rr_order[n]));
      check($sformatf("rr_latency_%0d", n), 32'(cyc), 32'd5);
      check($sformatf("rr_resp_err_%0d", n), 32'(resp_err), 32'd0);
      if (idx >= 0) req_valid[idx] = 1'b0;
      if (n == 1) req_valid[0] = 1'b1;
    end
    wait_ready(10, idx, cyc);
    check("rr_no_extra_pulse", 32'(idx), 32'hffff_ffff);
    check("rr_err_sticky", 32'(err_sticky), 32'd0);

    // Illegal command: requester 1, cmd 5
    set_cmd(1, 3'd5);
    req_valid = 4'b0010;
    step();
    check("ill_fsm_cmd_c1", 32'(fsm_cmd), 32'd0);
    check("ill_ready_c1", 32'(req_ready), 32'd0);
    step();
    check("ill_ready_c2", 32'(req_ready), 32'b0010);
    check("ill_resp_err", 32'(resp_err), 32'd1);
    check("ill_fsm_cmd_c2", 32'(fsm_cmd), 32'd0);
    check("ill_err_sticky", 32'(err_sticky), 32'd1);
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ill_fsm_cmd_after_%0d", k), 32'(fsm_cmd), 32'd0);
    end
    check("ill_sticky_holds", 32'(err_sticky), 32'd1);

    // Mismatch: model stuck at 0, requester 0, cmd 2
    do_reset();
    check("mm_sticky_cleared", 32'(err_sticky), 32'd0);
    stuck = 1'b1;
    set_cmd(0, 3'd2);
    req_valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("mm_fsm_cmd_c%0d", k + 1), 32'(fsm_cmd), 32'(exp_cmd_mm[k]));
      check($sformatf("mm_ready_c%0d", k + 1), 32'(req_ready), 32'(exp_rdy_mm[k]));
      if (k == 5) check("mm_busy_recover", 32'(busy), 32'd1);
    end
    check("mm_resp_err", 32'(resp_err), 32'd1);
    check("mm_err_sticky", 32'(err_sticky), 32'd1);
    req_valid = 4'b0000;
    stuck     = 1'b0;

    // Illegal internal state 111: recover, no pulse, sticky error
    do_reset();
    force dut.state_q = fsm_cmd_sched_pkg::state_e'(3'b111);
    #1;
    release dut.state_q;
    step();
    check("ist_busy_c1", 32'(busy), 32'd1);
    check("ist_sticky_c1", 32'(err_sticky), 32'd1);
    check("ist_fsm_cmd_c1", 32'(fsm_cmd), 32'd0);
    check("ist_ready_c1", 32'(req_ready), 32'd0);
    step();
    check("ist_busy_c2", 32'(busy), 32'd1);
    check("ist_ready_c2", 32'(req_ready), 32'd0);
    step();
    check("ist_busy_c3", 32'(busy), 32'd0);
    check("ist_ready_c3", 32'(req_ready), 32'd0);
    step();
    check("ist_ready_c4", 32'(req_ready), 32'd0);
    check("ist_sticky_holds", 32'(err_sticky), 32'd1);

    // Reset during DRIVE: requester 1 in flight, then requesters 0 and 2 after release
    set_cmd(1, 3'd1);
    req_valid = 4'b0010;
    step();
    step();
    check("rmo_drive_fsm_cmd", 32'(fsm_cmd), 32'd1);
    check("rmo_drive_busy", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    set_cmd(0, 3'd1);
    set_cmd(2, 3'd1);
    req_valid = 4'b0101;
    #1;
    check("rmo_fsm_cmd", 32'(fsm_cmd), 32'd0);
    check("rmo_busy", 32'(busy), 32'd0);
    check("rmo_grant_id", 32'(grant_id), 32'd0);
    check("rmo_err_sticky", 32'(err_sticky), 32'd0);
    check("rmo_ready", 32'(req_ready), 32'd0);
    step();
    check("rmo_ready_in_reset", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    wait_ready(12, idx, cyc);
    check("rmo_first_grant", 32'(idx), 32'd0);
    check("rmo_first_latency", 32'(cyc), 32'd5);
    if (idx >= 0) req_valid[idx] = 1'b0;
    wait_ready(12, idx, cyc);
    check("rmo_second_grant", 32'(idx), 32'd2);
    check("rmo_second_latency", 32'(cyc), 32'd5);
    req_valid = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm_cmd_sched.md
# fsm_cmd_sched

Command scheduler for the small mode FSM. Up to `NREQ` requesters share the FSM's 3-bit command input. The block arbitrates between requesters round-robin and rejects illegal command codes. It holds each accepted command on the FSM input for a fixed number of cycles, then checks the FSM's reported state before completing the handshake. Its own state machine is hardened: any unused encoding, or a state-check mismatch, forces a recovery sequence that drives the FSM back to state 0.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `HOLD_CYCLES`, default 2: cycles a command is held on `fsm_cmd`, 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request.
- `req_cmd`  in  3*NREQ  per-requester command; requester i uses bits [3i+2:3i].
- `req_ready`  out  NREQ  one-cycle completion pulse per requester.
- `resp_err`  out  1  qualifies `req_ready`: 1 means rejected or failed.
- `grant_id`  out  max(1,$clog2(NREQ))  index of the current or last granted requester.
- `fsm_cmd`  out  3  drives the FSM's command input.
- `fsm_state`  in  3  the FSM's state output.
- `busy`  out  1  high in every state except IDLE.
- `err_sticky`  out  1  set on an illegal command, a mismatch or an illegal internal state; cleared only by reset.

## Operation
- All outputs are registered. Reset values:
  - `req_ready` = 0, `resp_err` = 0, `grant_id` = 0, `fsm_cmd` = 0, `busy` = 0, `err_sticky` = 0.
  - State = IDLE; round-robin pointer `last` = NREQ-1, so requester 0 has top priority.
- Legal commands are 0, 1 and 2. Codes 3..7 are illegal and are never forwarded to `fsm_cmd`.
- The state register is 3 bits with the encodings below. The other three codes are unused; the next state from any of them is RECOVER, and `err_sticky` is set.
- IDLE (000):
  - `fsm_cmd` = 0.
  - Eligible requesters: `req_valid[i] & ~req_ready[i]`.
  - Any eligible requester → ARB.
- ARB (001), 1 cycle:
  - Pick the first eligible index searching from `last`+1, modulo NREQ.
  - Latch `grant_id` and the command; set `last` = the granted index.
  - If the command is illegal: pulse `req_ready[g]` with `resp_err` = 1, set `err_sticky`, go to IDLE.
  - If the command is legal: go to DRIVE.
  - If no requester is eligible any more (all withdrew): go to IDLE with no pulse.
- DRIVE (010):
  - `fsm_cmd` = the latched command for exactly `HOLD_CYCLES` cycles, counted by a 4-bit counter.
  - Then go to CHECK.
- CHECK (011), 1 cycle:
  - `fsm_cmd` stays at the latched command.
  - If `fsm_state` == {0, command}: pulse `req_ready[g]` with `resp_err` = 0, go to IDLE.
  - Otherwise: set `err_sticky` and go to RECOVER.
- RECOVER (100):
  - `fsm_cmd` = 0 for `HOLD_CYCLES` cycles.
  - Then pulse `req_ready[g]` with `resp_err` = 1 and go to IDLE.
  - When entered from an illegal state, no pulse is issued.
- `req_ready` is one-hot or zero and high for exactly one cycle. `resp_err` is 0 whenever `req_ready` is 0.
- Once granted, a transaction always runs to completion. Deasserting `req_valid` or changing `req_cmd` after ARB has no effect.

## Timing
- Legal command, valid first seen in IDLE at cycle 0:
  - ARB at cycle 1.
  - DRIVE at cycles 2..1+H, where H = `HOLD_CYCLES`.
  - CHECK at cycle 2+H.
  - `req_ready` high at cycle 3+H, with the state back in IDLE.
  - Total latency is H+3 cycles (5 at default).
- Illegal command: `req_ready` with `resp_err` high at cycle 2.
- Mismatch: RECOVER at cycles 3+H..2+2H; `req_ready` with `resp_err` high at cycle 3+2H.
- In the `req_ready` cycle the state is IDLE. The completing requester is excluded, so its still-high valid is not regranted. A new grant can start in the next cycle, back-to-back.
- Simultaneous requests are served in round-robin order. No requester waits more than NREQ-1 other transactions.
- Asserting `rst_n` low at any cycle immediately returns all outputs and state to their reset values. The in-flight transaction is dropped with no `req_ready` pulse.

## Test plan
- **Reset values:** reset, then idle → `fsm_cmd`=0, `busy`=0, `req_ready`=0, `err_sticky`=0.
- **Single legal command:** requester 2 sends cmd=1 and the FSM model follows it → `fsm_cmd`=1 for 3 cycles (DRIVE plus CHECK); `req_ready`=4'b0100 with `resp_err`=0 exactly 5 cycles after valid; `grant_id`=2.
- **Round-robin:** all 4 requesters valid from reset with cmd=2 → grants in order 0,1,2,3, one every 5 cycles, each pulsed once; requester 0 then re-requests → regranted only after 3.
- **Illegal command:** requester 1 sends cmd=5 → `fsm_cmd` never leaves 0; `req_ready`[1] with `resp_err`=1 at cycle 2; `err_sticky`=1 until reset.
- **Mismatch:** FSM model stuck at 0, cmd=2 → CHECK fails; `fsm_cmd`=0 for 2 cycles; `req_ready` with `resp_err`=1 at cycle 7.
- **Illegal state and reset mid-operation:** force state to 111 → RECOVER on the next cycle, then IDLE, no pulse, `err_sticky`=1. Pull `rst_n` low during DRIVE → all outputs 0 immediately, no pulse, requester 0 top priority after release.
